mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one pipelined `multiplier` instance (`DATA_LEN` wide, `PIPELINE_STAGE` deep, no stall input) between `NUM_REQ` requesters.
- Grants round-robin and issues at most one operation per cycle.
- Carries a requester tag through a shift register aligned to the multiplier latency, and returns each result as a one-hot pulse to its owner.
- Sits in the `clk` domain of the AFU, between the CSR/CCI sequencing FSMs and the datapath.

Parameters:
- `NUM_REQ`, 4, number of requesters (2..16).
- `DATA_LEN`, 32, operand/result width.
- `PIPELINE_STAGE`, 2, multiplier latency in cycles from registered operands to valid result (≥1).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: drops all in-flight operations.
- `req_valid` in `NUM_REQ`: per-requester request.
- `req_a` in `NUM_REQ*DATA_LEN`: operand a; requester i uses slice `[i*DATA_LEN +: DATA_LEN]`.
- `req_b` in `NUM_REQ*DATA_LEN`: operand b, same packing as `req_a`.
- `req_ready` out `NUM_REQ`: one-hot grant.
- `mul_a` out `DATA_LEN`: registered operand a to the multiplier.
- `mul_b` out `DATA_LEN`: registered operand b to the multiplier.
- `mul_reset` out 1: reset to the multiplier.
- `mul_result` in `DATA_LEN`: multiplier output.
- `rsp_valid` out `NUM_REQ`: one-hot result strobe.
- `rsp_result` out `DATA_LEN`: result data, valid when any `rsp_valid` bit is set.
- `outstanding` out `$clog2(NUM_REQ*(PIPELINE_STAGE+2))+1`: count of operations in flight.
- `issue_count` out 32: total accepted operations.

Behaviour:
- **Reset values:** every output is 0; rr pointer = 0; tag pipeline valid bits = 0.
- **`mul_reset`:** equals `reset | flush`, registered by one cycle.
- **Grant (combinational):**
  - Search from the rr pointer upward, wrapping; the first i with `req_valid[i]` gets `req_ready[i]=1`.
  - All other bits are 0.
  - `req_ready` is all-zero while `reset` or `flush` is high.
- **Accept:** `req_valid[i] & req_ready[i]`.
  - Requesters hold `req_valid` and operands stable until accepted; `req_ready` never depends on data.
  - On accept, the pointer becomes `(i+1) mod NUM_REQ`.
  - With no accept, the pointer holds.
- **Issue:**
  - At the accept edge, `mul_a`/`mul_b` load the granted operands.
  - In idle cycles they load 0.
  - The tag pipeline stage 0 loads `{valid=1, idx=i}`, otherwise `{0, x}`.
- **Tag pipeline:**
  - Depth `PIPELINE_STAGE+1`, shifts every cycle with no stall.
  - When the last stage is valid, it registers `rsp_valid[idx]=1` and `rsp_result=mul_result` (low `DATA_LEN` bits of a*b, modulo 2^`DATA_LEN`).
  - Otherwise `rsp_valid=0` and `rsp_result` holds its previous value.
- **Latency:**
  - An op accepted in cycle t produces `rsp_valid` in cycle t+`PIPELINE_STAGE`+2.
  - Throughput is 1 op/cycle; responses return in issue order.
- **No response backpressure:** the requester must sink the `rsp_valid` pulse in the cycle it is asserted.
- **`outstanding`:**
  - +1 on accept, −1 on response, unchanged when both happen in the same cycle.
  - Never underflows.
- **`issue_count`:** +1 per accept, wraps 0xFFFFFFFF→0.
- **`flush` (one cycle or longer):**
  - Next cycle: all tag valid bits = 0, `outstanding` = 0, `mul_a`/`mul_b` = 0.
  - No `rsp_valid` occurs for ops accepted before or during the flush.
  - `issue_count` and the rr pointer are preserved.
- **`reset` mid-operation:** same as flush, and additionally clears the pointer and `issue_count`.
- **Single requester:** a continuous `req_valid` is granted every cycle.
- **All requesters active:** grants rotate 0,1,…,`NUM_REQ`−1,0 with no starvation; the wait is bounded by `NUM_REQ`−1 cycles.

Test Plan:
- **Single op:** req0 a=3, b=5 accepted at t → `rsp_valid=0001`, `rsp_result=15` at t+4 (defaults); `outstanding` 1 for cycles t+1..t+4, then 0.
- **Overflow:** req2 a=0xFFFFFFFF, b=2 → `rsp_valid=0100`, `rsp_result=0xFFFFFFFE`; a=0x10000, b=0x10000 → 0.
- **Fairness:** all four `req_valid` held for 8 cycles → grant order 0,1,2,3,0,1,2,3; 8 responses in the same order; `issue_count=8`.
- **Back-to-back streaming:** req1 streams a=k, b=k for k=1..6 → results 1,4,9,16,25,36 on consecutive cycles, all with `rsp_valid=0010`.
- **Flush:** issue 3 ops, assert `flush` one cycle later → no `rsp_valid` ever; `outstanding=0`; `mul_reset` pulses; a following op (7×6) returns 42 with normal latency.
- **Reset mid-stream:** reset while 2 ops are in flight and the pointer =2 → all outputs 0, the pointer returns to 0 (next grant with all requesting is req0), `issue_count=0`.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// mul_share_arbiter
//
// Shares one external pipelined multiplier between NUM_REQ requesters.
// Requests are granted round-robin, one per cycle. The granted operands are
// registered onto mul_a/mul_b. A requester tag travels through a shift
// register whose depth matches the multiplier latency. When the tag reaches
// the end of that register, the multiplier result is registered and returned
// to its owner as a one-hot strobe.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   flush        drops every in-flight operation (pointer/issue count kept)
//   req_valid    per-requester request
//   req_a/req_b  packed operands, requester i at [i*DATA_LEN +: DATA_LEN]
//   req_ready    one-hot combinational grant
//   mul_a/mul_b  registered operands to the multiplier
//   mul_reset    registered (reset | flush) to the multiplier
//   mul_result   multiplier output, PIPELINE_STAGE cycles after mul_a/mul_b
//   rsp_valid    one-hot result strobe, no backpressure
//   rsp_result   result data, held between strobes
//   outstanding  operations accepted but not yet returned
//   issue_count  total accepted operations, wrapping
// ---------------------------------------------------------------------------
module mul_share_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_LEN       = 32,
  parameter int PIPELINE_STAGE = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          flush,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [NUM_REQ*DATA_LEN-1:0]                   req_a,
  input  logic [NUM_REQ*DATA_LEN-1:0]                   req_b,
  output logic [NUM_REQ-1:0]                            req_ready,
  output logic [DATA_LEN-1:0]                           mul_a,
  output logic [DATA_LEN-1:0]                           mul_b,
  output logic                                          mul_reset,
  input  logic [DATA_LEN-1:0]                           mul_result,
  output logic [NUM_REQ-1:0]                            rsp_valid,
  output logic [DATA_LEN-1:0]                           rsp_result,
  output logic [$clog2(NUM_REQ*(PIPELINE_STAGE+2)):0]   outstanding,
  output logic [31:0]                                   issue_count
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(NUM_REQ*(PIPELINE_STAGE+2)) + 1;
  localparam int LAST  = PIPELINE_STAGE;

  // Decode a requester index into a one-hot vector.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = {NUM_REQ{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Arbitration state and combinational grant signals
  logic [PTR_W-1:0]    rr_ptr_r;
  logic [PTR_W:0]      cand_sum_s;
  logic [PTR_W-1:0]    cand_idx_s;
  logic                cand_hit_s;
  logic                grant_found_s;
  logic [PTR_W-1:0]    grant_idx_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic                accept_s;
  logic [DATA_LEN-1:0] sel_a_s;
  logic [DATA_LEN-1:0] sel_b_s;

  // Datapath and bookkeeping registers
  logic [DATA_LEN-1:0]   mul_a_r;
  logic [DATA_LEN-1:0]   mul_b_r;
  logic                  mul_reset_r;
  logic [LAST:0]         tag_valid_r;
  logic [PTR_W-1:0]      tag_idx_r [0:LAST];
  logic [NUM_REQ-1:0]    rsp_valid_r;
  logic [DATA_LEN-1:0]   rsp_result_r;
  logic                  rsp_any_s;
  logic [CNT_W-1:0]      outstanding_r;
  logic [31:0]           issue_count_r;

  // Round-robin search: the first valid requester at or after the pointer,
  // wrapping. The pointer and the loop offset are both below NUM_REQ, so one
  // conditional subtraction is enough for the modulo.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {PTR_W{1'b0}};
    cand_sum_s    = {(PTR_W+1){1'b0}};
    cand_idx_s    = {PTR_W{1'b0}};
    cand_hit_s    = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_sum_s    = {1'b0, rr_ptr_r} + (PTR_W+1)'(off);
      cand_idx_s    = (cand_sum_s >= (PTR_W+1)'(NUM_REQ)) ?
                      PTR_W'(cand_sum_s - (PTR_W+1)'(NUM_REQ)) :
                      cand_sum_s[PTR_W-1:0];
      cand_hit_s    = req_valid[cand_idx_s] & ~grant_found_s;
      grant_idx_s   = cand_hit_s ? cand_idx_s : grant_idx_s;
      grant_found_s = grant_found_s | cand_hit_s;
    end
  end

  // Gate the grant off while reset or flush is active.
  always_comb begin
    grant_s = {NUM_REQ{1'b0}};
    if (grant_found_s && !reset && !flush) begin
      grant_s = idx_to_onehot(grant_idx_s);
    end else begin
      grant_s = {NUM_REQ{1'b0}};
    end
  end

  assign req_ready = grant_s;
  // A grant is only ever given to a valid requester, so any grant is an accept.
  assign accept_s  = |grant_s;

  // Operand mux for the granted requester
  always_comb begin
    sel_a_s = {DATA_LEN{1'b0}};
    sel_b_s = {DATA_LEN{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a_s = (grant_idx_s == PTR_W'(i)) ? req_a[i*DATA_LEN +: DATA_LEN] : sel_a_s;
      sel_b_s = (grant_idx_s == PTR_W'(i)) ? req_b[i*DATA_LEN +: DATA_LEN] : sel_b_s;
    end
  end

  // Round-robin pointer: moves past the accepted requester and holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r <= {PTR_W{1'b0}};
    end else if (accept_s) begin
      rr_ptr_r <= (grant_idx_s == PTR_W'(NUM_REQ-1)) ? {PTR_W{1'b0}} :
                  grant_idx_s + PTR_W'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Operand registers feeding the multiplier; idle cycles present zero.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mul_a_r <= {DATA_LEN{1'b0}};
      mul_b_r <= {DATA_LEN{1'b0}};
    end else if (accept_s) begin
      mul_a_r <= sel_a_s;
      mul_b_r <= sel_b_s;
    end else begin
      mul_a_r <= {DATA_LEN{1'b0}};
      mul_b_r <= {DATA_LEN{1'b0}};
    end
  end

  // Multiplier reset: the reset/flush request delayed by one cycle.
  always_ff @(posedge clk) begin
    mul_reset_r <= reset | flush;
  end

  // Tag shift register. Stage 0 lines up with mul_a/mul_b, and the last stage
  // lines up with mul_result. It advances every cycle because the multiplier
  // cannot stall.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      tag_valid_r <= {(LAST+1){1'b0}};
      for (int s = 0; s <= LAST; s++) begin
        tag_idx_r[s] <= {PTR_W{1'b0}};
      end
    end else begin
      tag_valid_r  <= {tag_valid_r[LAST-1:0], accept_s};
      tag_idx_r[0] <= accept_s ? grant_idx_s : {PTR_W{1'b0}};
      for (int s = 1; s <= LAST; s++) begin
        tag_idx_r[s] <= tag_idx_r[s-1];
      end
    end
  end

  // Response register. A flush suppresses a response that would otherwise
  // register in the flush cycle, and rsp_result keeps its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_r  <= {NUM_REQ{1'b0}};
      rsp_result_r <= {DATA_LEN{1'b0}};
    end else if (flush) begin
      rsp_valid_r  <= {NUM_REQ{1'b0}};
      rsp_result_r <= rsp_result_r;
    end else if (tag_valid_r[LAST]) begin
      rsp_valid_r  <= idx_to_onehot(tag_idx_r[LAST]);
      rsp_result_r <= mul_result;
    end else begin
      rsp_valid_r  <= {NUM_REQ{1'b0}};
      rsp_result_r <= rsp_result_r;
    end
  end

  assign rsp_any_s = |rsp_valid_r;

  // In-flight count. A response is counted in the cycle its strobe is
  // visible, so an op stays outstanding up to and including that cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      outstanding_r <= {CNT_W{1'b0}};
    end else if (accept_s && !rsp_any_s) begin
      outstanding_r <= outstanding_r + CNT_W'(1);
    end else if (!accept_s && rsp_any_s && (outstanding_r != {CNT_W{1'b0}})) begin
      outstanding_r <= outstanding_r - CNT_W'(1);
    end else begin
      outstanding_r <= outstanding_r;
    end
  end

  // Total accepted operations; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_count_r <= 32'd0;
    end else if (accept_s) begin
      issue_count_r <= issue_count_r + 32'd1;
    end else begin
      issue_count_r <= issue_count_r;
    end
  end

  assign mul_a       = mul_a_r;
  assign mul_b       = mul_b_r;
  assign mul_reset   = mul_reset_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_result  = rsp_result_r;
  assign outstanding = outstanding_r;
  assign issue_count = issue_count_r;

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int P = 2;

  logic           clk;
  logic           reset;
  logic           flush;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_reset;
  logic [W-1:0]   mul_result;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_result;
  logic [4:0]     outstanding;
  logic [31:0]    issue_count;

  mul_share_arbiter #(.NUM_REQ(N), .DATA_LEN(W), .PIPELINE_STAGE(P)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_reset(mul_reset), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .outstanding(outstanding), .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: P cycles from registered operands to result.
  logic [W-1:0] mpipe [0:P-1];
  always @(posedge clk) begin
    mpipe[0] <= mul_a * mul_b;
    for (int s = 1; s < P; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mul_result = mpipe[P-1];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic ok,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard of expected responses
  typedef struct {
    int          idx;
    logic [31:0] res;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state
  int          ptr_m   = 0;
  logic [31:0] issue_m = 32'd0;
  logic [31:0] opa [N];
  logic [31:0] opb [N];

  exp_t       mon_e;
  logic [3:0] mon_oh;
  always @(negedge clk) begin
    if (rsp_valid != 4'b0000) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 1'b0, 64'(rsp_valid), 64'd0);
      end else begin
        mon_e  = sb_q.pop_front();
        mon_oh = 4'b0001 << mon_e.idx;
        check("rsp_onehot", rsp_valid == mon_oh, 64'(rsp_valid), 64'(mon_oh));
        check("rsp_result", rsp_result == mon_e.res, 64'(rsp_result), 64'(mon_e.res));
        check("rsp_latency", cyc == mon_e.due, 64'(cyc), 64'(mon_e.due));
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      mon_e = sb_q.pop_front();
      check("missing_rsp", 1'b0, 64'(cyc), 64'(mon_e.due));
    end
  end

  // One clock cycle of stimulus, entered and left 1 time unit after a rising edge.
  task automatic cycle_op(input logic [3:0] v, input logic fl, input logic rs,
                          input logic has_exp, input logic [31:0] exp_val,
                          output logic [3:0] seen);
    logic [3:0] exp_g;
    int         gi;
    exp_t       e;
    exp_t       keep[$];
    req_valid = v;
    flush     = fl;
    reset     = rs;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
    end
    @(negedge clk);
    exp_g = 4'b0000;
    gi    = -1;
    if (!fl && !rs) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr_m + k) % N;
        if (gi < 0 && v[j]) gi = j;
      end
    end
    if (gi >= 0) exp_g[gi] = 1'b1;
    seen = req_ready;
    check("grant", req_ready == exp_g, 64'(req_ready), 64'(exp_g));
    if (gi >= 0) begin
      e.idx = gi;
      e.res = has_exp ? exp_val : 32'(opa[gi] * opb[gi]);
      e.due = cyc + P + 2;
      sb_q.push_back(e);
      ptr_m   = (gi + 1) % N;
      issue_m = issue_m + 32'd1;
    end
    if (fl || rs) begin
      foreach (sb_q[q]) if (sb_q[q].due <= cyc) keep.push_back(sb_q[q]);
      sb_q = keep;
      if (rs) begin
        ptr_m   = 0;
        issue_m = 32'd0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic [3:0] s;
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) cycle_op(4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, s);
    check("drain", sb_q.size() == 0, 64'(sb_q.size()), 64'd0);
  endtask

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[6];

  logic [3:0] seen;

  initial begin
    vecs[0] = '{0, 32'd3,          32'd5,       32'd15};
    vecs[1] = '{2, 32'hFFFF_FFFF,  32'd2,       32'hFFFF_FFFE};
    vecs[2] = '{2, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000};
    vecs[3] = '{3, 32'd0,          32'd123,     32'd0};
    vecs[4] = '{1, 32'h0000_FFFF,  32'h0000_FFFF, 32'hFFFE_0001};
    vecs[5] = '{0, 32'h1234_5678,  32'd16,      32'h2345_6780};

    reset = 1'b1; flush = 1'b0; req_valid = 4'b0000;
    req_a = {(N*W){1'b0}}; req_b = {(N*W){1'b0}};
    for (int i = 0; i < N; i++) begin
      opa[i] = 32'(i + 2);
      opb[i] = 32'(i + 3);
    end
    @(posedge clk); #1;

    // Reset: requests present but no grant; all outputs cleared
    for (int k = 0; k < 3; k++) cycle_op(4'b1111, 1'b0, 1'b1, 1'b0, 32'd0, seen);
    check("rst_mul_a", mul_a == 32'd0, 64'(mul_a), 64'd0);
    check("rst_mul_b", mul_b == 32'd0, 64'(mul_b), 64'd0);
    check("rst_rsp_valid", rsp_valid == 4'b0000, 64'(rsp_valid), 64'd0);
    check("rst_rsp_result", rsp_result == 32'd0, 64'(rsp_result), 64'd0);
    check("rst_outstanding", outstanding == 5'd0, 64'(outstanding), 64'd0);
    check("rst_issue_count", issue_count == 32'd0, 64'(issue_count), 64'd0);
    check("rst_mul_reset", mul_reset == 1'b1, 64'(mul_reset), 64'd1);

    // Fairness: all four requesting for 8 cycles
    for (int k = 0; k < 8; k++) begin
      cycle_op(4'b1111, 1'b0, 1'b0, 1'b0, 32'd0, seen);
      check("fair_order", seen == (4'b0001 << (k % 4)), 64'(seen), 64'(4'b0001 << (k % 4)));
      if (k == 0) check("mul_reset_release", mul_reset == 1'b0, 64'(mul_reset), 64'd0);
    end
    check("fair_outstanding", outstanding == 5'd4, 64'(outstanding), 64'd4);
    check("fair_issue_count", issue_count == 32'd8, 64'(issue_count), 64'd8);
    drain();

    // Table-driven single-requester ops
    foreach (vecs[k]) begin
      opa[vecs[k].req] = vecs[k].a;
      opb[vecs[k].req] = vecs[k].b;
      cycle_op(4'b0001 << vecs[k].req, 1'b0, 1'b0, 1'b1, vecs[k].exp, seen);
    end
    drain();
    check("table_issue_count", issue_count == issue_m, 64'(issue_count), 64'(issue_m));

    // Single op: outstanding is 1 from t+1 to t+4, then 0
    opa[0] = 32'd3; opb[0] = 32'd5;
    cycle_op(4'b0001, 1'b0, 1'b0, 1'b1, 32'd15, seen);
    for (int k = 1; k <= 5; k++) begin
      check("single_outstanding", outstanding == ((k <= 4) ? 5'd1 : 5'd0),
            64'(outstanding), (k <= 4) ? 64'd1 : 64'd0);
      cycle_op(4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, seen);
    end

    // Back-to-back streaming from req1
    for (int k = 1; k <= 6; k++) begin
      opa[1] = 32'(k); opb[1] = 32'(k);
      cycle_op(4'b0010, 1'b0, 1'b0, 1'b1, 32'(k * k), seen);
    end
    drain();

    // Flush with three ops in flight
    for (int k = 0; k < 3; k++) begin
      opa[3] = 32'(2 * k + 2); opb[3] = 32'(2 * k + 3);
      cycle_op(4'b1000, 1'b0, 1'b0, 1'b0, 32'd0, seen);
    end
    cycle_op(4'b1111, 1'b1, 1'b0, 1'b0, 32'd0, seen);
    check("flush_outstanding", outstanding == 5'd0, 64'(outstanding), 64'd0);
    check("flush_mul_a", mul_a == 32'd0, 64'(mul_a), 64'd0);
    check("flush_mul_reset", mul_reset == 1'b1, 64'(mul_reset), 64'd1);
    check("flush_issue_count", issue_count == issue_m, 64'(issue_count), 64'(issue_m));
    for (int k = 0; k < 6; k++) begin
      check("flush_quiet", rsp_valid == 4'b0000, 64'(rsp_valid), 64'd0);
      cycle_op(4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, seen);
    end
    check("flush_mul_reset_end", mul_reset == 1'b0, 64'(mul_reset), 64'd0);
    opa[2] = 32'd7; opb[2] = 32'd6;
    cycle_op(4'b0100, 1'b0, 1'b0, 1'b1, 32'd42, seen);
    drain();

    // Reset mid-stream: two ops in flight, pointer at 2
    opa[0] = 32'd11; opb[0] = 32'd2;
    opa[1] = 32'd13; opb[1] = 32'd3;
    cycle_op(4'b0001, 1'b0, 1'b0, 1'b0, 32'd0, seen);
    cycle_op(4'b0010, 1'b0, 1'b0, 1'b0, 32'd0, seen);
    cycle_op(4'b1111, 1'b0, 1'b1, 1'b0, 32'd0, seen);
    check("mid_rst_rsp_valid", rsp_valid == 4'b0000, 64'(rsp_valid), 64'd0);
    check("mid_rst_rsp_result", rsp_result == 32'd0, 64'(rsp_result), 64'd0);
    check("mid_rst_outstanding", outstanding == 5'd0, 64'(outstanding), 64'd0);
    check("mid_rst_issue_count", issue_count == 32'd0, 64'(issue_count), 64'd0);
    check("mid_rst_mul_a", mul_a == 32'd0, 64'(mul_a), 64'd0);
    cycle_op(4'b1111, 1'b0, 1'b0, 1'b0, 32'd0, seen);
    check("mid_rst_ptr", seen == 4'b0001, 64'(seen), 64'd1);
    check("mid_rst_issue_after", issue_count == 32'd1, 64'(issue_count), 64'd1);
    drain();
    for (int k = 0; k < 4; k++) cycle_op(4'b0000, 1'b0, 1'b0, 1'b0, 32'd0, seen);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
